// File: rtl/axis_route4.sv
// rtl/axis_route4.sv - 1-to-4 AXI-Stream packet router with per-output 2-entry skid buffers
// Route is taken from the head flit and held until TLAST when TLAST_ARB=1.
module axis_route4 #(
   parameter int DATA_WIDTH = 8,
   parameter int DEST_LSB   = 0,
   parameter bit TLAST_ARB  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_TDATA,
   input  logic                  s_TVALID,
   output logic                  s_TREADY,
   input  logic                  s_TLAST,
   output logic [DATA_WIDTH-1:0] o0_TDATA,
   output logic                  o0_TVALID,
   input  logic                  o0_TREADY,
   output logic                  o0_TLAST,
   output logic [DATA_WIDTH-1:0] o1_TDATA,
   output logic                  o1_TVALID,
   input  logic                  o1_TREADY,
   output logic                  o1_TLAST,
   output logic [DATA_WIDTH-1:0] o2_TDATA,
   output logic                  o2_TVALID,
   input  logic                  o2_TREADY,
   output logic                  o2_TLAST,
   output logic [DATA_WIDTH-1:0] o3_TDATA,
   output logic                  o3_TVALID,
   input  logic                  o3_TREADY,
   output logic                  o3_TLAST,
   output logic                  locked,
   output logic [1:0]            cur_dest
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_cur_dest;
   logic [1:0]            w_cur_dest_nxt;
   logic [1:0]            w_sel;
   logic                  w_accept;
   logic [3:0]            w_out_ready;
   logic [3:0]            w_wr;
   logic [3:0]            w_rd;
   logic [3:0]            w_idx;
   logic [DATA_WIDTH-1:0] r_data [4][2];
   logic                  r_last [4][2];
   logic [1:0]            r_cnt  [4];

   assign w_out_ready = {o3_TREADY, o2_TREADY, o1_TREADY, o0_TREADY};
   assign w_sel       = (r_state == ST_IDLE || !TLAST_ARB) ? s_TDATA[DEST_LSB +: 2] : r_cur_dest;
   assign s_TREADY    = rst & (r_cnt[w_sel] < 2'd2);
   assign w_accept    = s_TVALID & s_TREADY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cur_dest <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_dest <= w_cur_dest_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_dest_nxt = r_cur_dest;
      if (w_accept && TLAST_ARB) begin
         if (r_state == ST_IDLE && !s_TLAST) begin
            w_state_nxt    = ST_LOCKED;
            w_cur_dest_nxt = w_sel;
         end else if (r_state == ST_LOCKED && s_TLAST) begin
            w_state_nxt    = ST_IDLE;
            w_cur_dest_nxt = 2'd0;
         end
      end
   end

   // Slot 0 is always the head; a read shifts slot 1 down, so the write lands at cnt-rd.
   always_comb begin
      w_wr  = '0;
      w_rd  = '0;
      w_idx = '0;
      for (int n = 0; n < 4; n++) begin
         w_wr[n]  = w_accept && (w_sel == 2'(n));
         w_rd[n]  = (r_cnt[n] != 2'd0) && w_out_ready[n];
         w_idx[n] = (r_cnt[n] - 2'(w_rd[n])) != 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 4; n++) begin
            r_cnt[n]     <= 2'd0;
            r_data[n][0] <= '0;
            r_data[n][1] <= '0;
            r_last[n][0] <= 1'b0;
            r_last[n][1] <= 1'b0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (w_rd[n]) begin
               r_data[n][0] <= r_data[n][1];
               r_last[n][0] <= r_last[n][1];
            end
            if (w_wr[n]) begin
               if (w_idx[n]) begin
                  r_data[n][1] <= s_TDATA;
                  r_last[n][1] <= s_TLAST;
               end else begin
                  r_data[n][0] <= s_TDATA;
                  r_last[n][0] <= s_TLAST;
               end
            end
            r_cnt[n] <= r_cnt[n] + 2'(w_wr[n]) - 2'(w_rd[n]);
         end
      end
   end

   assign o0_TDATA  = r_data[0][0];
   assign o0_TLAST  = r_last[0][0];
   assign o0_TVALID = r_cnt[0] != 2'd0;
   assign o1_TDATA  = r_data[1][0];
   assign o1_TLAST  = r_last[1][0];
   assign o1_TVALID = r_cnt[1] != 2'd0;
   assign o2_TDATA  = r_data[2][0];
   assign o2_TLAST  = r_last[2][0];
   assign o2_TVALID = r_cnt[2] != 2'd0;
   assign o3_TDATA  = r_data[3][0];
   assign o3_TLAST  = r_last[3][0];
   assign o3_TVALID = r_cnt[3] != 2'd0;

   assign locked    = r_state == ST_LOCKED;
   assign cur_dest  = r_cur_dest;

endmodule

// File: tb/tb_axis_route4.sv
// tb/tb_axis_route4.sv - directed vector table, corner sequences and scoreboard soak for axis_route4
module tb_axis_route4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_TDATA = 8'h00;
   logic       s_TVALID = 1'b0;
   logic       s_TLAST = 1'b0;
   logic       s_TREADY;
   logic [3:0] o_rdy = 4'h0;
   logic [7:0] o0_TDATA, o1_TDATA, o2_TDATA, o3_TDATA;
   logic       o0_TVALID, o1_TVALID, o2_TVALID, o3_TVALID;
   logic       o0_TLAST, o1_TLAST, o2_TLAST, o3_TLAST;
   logic       locked;
   logic [1:0] cur_dest;
   logic [3:0] ov;
   logic [3:0] ol;
   logic [7:0] od [4];

   assign ov    = {o3_TVALID, o2_TVALID, o1_TVALID, o0_TVALID};
   assign ol    = {o3_TLAST, o2_TLAST, o1_TLAST, o0_TLAST};
   assign od[0] = o0_TDATA;
   assign od[1] = o1_TDATA;
   assign od[2] = o2_TDATA;
   assign od[3] = o3_TDATA;

   axis_route4 dut (
      .clk(clk), .rst(rst),
      .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TLAST(s_TLAST),
      .o0_TDATA(o0_TDATA), .o0_TVALID(o0_TVALID), .o0_TREADY(o_rdy[0]), .o0_TLAST(o0_TLAST),
      .o1_TDATA(o1_TDATA), .o1_TVALID(o1_TVALID), .o1_TREADY(o_rdy[1]), .o1_TLAST(o1_TLAST),
      .o2_TDATA(o2_TDATA), .o2_TVALID(o2_TVALID), .o2_TREADY(o_rdy[2]), .o2_TLAST(o2_TLAST),
      .o3_TDATA(o3_TDATA), .o3_TVALID(o3_TVALID), .o3_TREADY(o_rdy[3]), .o3_TLAST(o3_TLAST),
      .locked(locked), .cur_dest(cur_dest)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic [3:0] rdy;
      logic       srdy;
      logic [3:0] ov;
      logic       lk;
      logic [1:0] cd;
      int         port;
      logic [7:0] od;
      logic       ol;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic [3:0] rdy,
                               input logic srdy, input logic [3:0] eov, input logic lk, input logic [1:0] cd,
                               input int port, input logic [7:0] eod, input logic eol);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.rdy = rdy;
      t.srdy = srdy; t.ov = eov; t.lk = lk; t.cd = cd;
      t.port = port; t.od = eod; t.ol = eol;
      return t;
   endfunction

   // Each row: inputs driven after a rising edge, outputs sampled on the following falling edge.
   task automatic run_vectors();
      foreach (tv[i]) begin
         s_TVALID = tv[i].v;
         s_TDATA  = tv[i].d;
         s_TLAST  = tv[i].l;
         o_rdy    = tv[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d.s_tready", i), s_TREADY, tv[i].srdy);
         check($sformatf("vec%0d.tvalid", i), ov, tv[i].ov);
         check($sformatf("vec%0d.locked", i), locked, tv[i].lk);
         check($sformatf("vec%0d.cur_dest", i), cur_dest, tv[i].cd);
         if (tv[i].ov[tv[i].port]) begin
            check($sformatf("vec%0d.o%0d_tdata", i, tv[i].port), od[tv[i].port], tv[i].od);
            check($sformatf("vec%0d.o%0d_tlast", i, tv[i].port), ol[tv[i].port], tv[i].ol);
         end
         @(posedge clk);
         #1;
      end
   endtask

   logic [8:0] q [4][$];
   logic       m_lock = 1'b0;
   logic [1:0] m_dest = 2'd0;
   logic [1:0] sel;
   logic [8:0] exp_flit;
   logic       acc;
   logic [1:0] pdest;
   logic [5:0] seq;
   int         rem;

   initial begin
      // packet lock: 0x09 carries field 1 but must stay on o0
      tv.push_back(mk(1, 8'h04, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 8'h00, 0));
      tv.push_back(mk(1, 8'h09, 0, 4'hF, 1, 4'b0001, 1, 0, 0, 8'h04, 0));
      tv.push_back(mk(1, 8'h0E, 1, 4'hF, 1, 4'b0001, 1, 0, 0, 8'h09, 0));
      tv.push_back(mk(0, 8'h00, 0, 4'hF, 1, 4'b0001, 0, 0, 0, 8'h0E, 1));
      tv.push_back(mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 8'h00, 0));
      // backpressure isolation on o2
      tv.push_back(mk(1, 8'h06, 1, 4'b1011, 1, 4'b0000, 0, 0, 0, 8'h00, 0));
      tv.push_back(mk(1, 8'h0A, 1, 4'b1011, 1, 4'b0100, 0, 0, 2, 8'h06, 1));
      tv.push_back(mk(1, 8'h0E, 1, 4'b1011, 0, 4'b0100, 0, 0, 2, 8'h06, 1));
      tv.push_back(mk(1, 8'h05, 1, 4'b1011, 1, 4'b0100, 0, 0, 2, 8'h06, 1));
      tv.push_back(mk(0, 8'h00, 0, 4'b1011, 1, 4'b0110, 0, 0, 1, 8'h05, 1));
      tv.push_back(mk(0, 8'h00, 0, 4'b1111, 1, 4'b0100, 0, 0, 2, 8'h06, 1));
      tv.push_back(mk(0, 8'h00, 0, 4'b1111, 1, 4'b0100, 0, 0, 2, 8'h0A, 1));
      tv.push_back(mk(0, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 8'h00, 0));

      // reset held with a valid source and ready sinks
      rst = 1'b0; s_TVALID = 1'b1; s_TDATA = 8'h01; s_TLAST = 1'b1; o_rdy = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.s_tready", s_TREADY, 0);
      check("rst.tvalid", ov, 4'b0000);
      check("rst.locked", locked, 0);
      check("rst.cur_dest", cur_dest, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rel.s_tready", s_TREADY, 1);
      check("rel.tvalid_pre", ov, 4'b0000);
      @(posedge clk);
      #1 s_TVALID = 1'b0;
      @(negedge clk);
      check("rel.tvalid", ov, 4'b0010);
      check("rel.o1_tdata", o1_TDATA, 8'h01);
      @(posedge clk);
      #1;

      run_vectors();

      // sustained throughput to o3
      o_rdy = 4'hF;
      for (int i = 0; i <= 32; i++) begin
         if (i < 32) begin
            s_TVALID = 1'b1;
            s_TDATA  = 8'(4 * i + 3);
            s_TLAST  = (i == 31);
         end else begin
            s_TVALID = 1'b0;
         end
         @(negedge clk);
         if (i < 32) check($sformatf("thr%0d.s_tready", i), s_TREADY, 1);
         if (i > 0) begin
            check($sformatf("thr%0d.o3_tvalid", i), o3_TVALID, 1);
            check($sformatf("thr%0d.o3_tdata", i), o3_TDATA, 4 * (i - 1) + 3);
         end
         @(posedge clk);
         #1;
      end

      // reset in the middle of a packet to o1
      o_rdy = 4'h0;
      s_TVALID = 1'b1; s_TDATA = 8'h05; s_TLAST = 1'b0;
      @(posedge clk);
      #1 s_TDATA = 8'h08;
      @(posedge clk);
      #1 s_TVALID = 1'b0;
      @(negedge clk);
      check("mid.locked_pre", locked, 1);
      check("mid.cur_dest_pre", cur_dest, 1);
      check("mid.o1_tvalid_pre", o1_TVALID, 1);
      rst = 1'b0;
      #1;
      check("mid.o1_tvalid", o1_TVALID, 0);
      check("mid.locked", locked, 0);
      check("mid.s_tready", s_TREADY, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      o_rdy = 4'hF; s_TVALID = 1'b1; s_TDATA = 8'h0B; s_TLAST = 1'b1;
      @(negedge clk);
      check("mid.s_tready_rel", s_TREADY, 1);
      check("mid.tvalid_rel", ov, 4'b0000);
      @(posedge clk);
      #1 s_TVALID = 1'b0;
      @(negedge clk);
      check("mid.tvalid_o3", ov, 4'b1000);
      check("mid.o3_tdata", o3_TDATA, 8'h0B);
      check("mid.locked_post", locked, 0);
      @(posedge clk);
      #1;

      // random soak against a queue-per-output scoreboard
      acc = 1'b0; rem = 0; seq = 6'd0; pdest = 2'd0;
      s_TVALID = 1'b0;
      for (int c = 0; c < 40020; c++) begin
         if (acc) s_TVALID = 1'b0;
         o_rdy = (c < 40000) ? 4'($urandom) : 4'hF;
         if (!s_TVALID && c < 40000 && $urandom_range(0, 3) != 0) begin
            if (rem == 0) begin
               rem     = $urandom_range(1, 4);
               pdest   = 2'($urandom);
               s_TDATA = {seq, pdest};
            end else begin
               s_TDATA = {seq, 2'($urandom)};
            end
            seq++;
            s_TLAST  = (rem == 1);
            rem--;
            s_TVALID = 1'b1;
         end
         @(negedge clk);
         sel = m_lock ? m_dest : s_TDATA[1:0];
         check("soak.s_tready", s_TREADY, q[sel].size() < 2);
         check("soak.tvalid", ov, {q[3].size() != 0, q[2].size() != 0, q[1].size() != 0, q[0].size() != 0});
         check("soak.locked", locked, m_lock);
         check("soak.cur_dest", cur_dest, m_lock ? m_dest : 2'd0);
         for (int n = 0; n < 4; n++) begin
            if (ov[n] && o_rdy[n] && q[n].size() != 0) begin
               exp_flit = q[n].pop_front();
               check($sformatf("soak.o%0d_flit", n), {ol[n], od[n]}, exp_flit);
            end
         end
         acc = s_TVALID && s_TREADY;
         if (acc) begin
            q[sel].push_back({s_TLAST, s_TDATA});
            if (s_TLAST) m_lock = 1'b0;
            else begin
               m_lock = 1'b1;
               m_dest = sel;
            end
         end
         @(posedge clk);
         #1;
      end
      for (int n = 0; n < 4; n++) check($sformatf("soak.drain%0d", n), q[n].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
